// File: rtl/alu_multiword_sequencer_pkg.sv
// rtl/alu_multiword_sequencer_pkg.sv - shared types and helpers for the multi-word alu sequencer
package alu_multiword_sequencer_pkg;

   localparam int SEQ_MAX_WORDS = 8;
   localparam int SEQ_LEN_W     = $clog2(SEQ_MAX_WORDS + 1);
   localparam int WORD_W        = 32;

   typedef logic [WORD_W-1:0] MICRO1_MACHINE_WORD;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4
   } ALU_OPERATION;

   typedef enum logic [1:0] {
      ALU_SEQ_IDLE  = 2'd0,
      ALU_SEQ_RUN   = 2'd1,
      ALU_SEQ_FLUSH = 2'd2
   } ALU_SEQ_STATE;

   function automatic logic alu_op_chains_carry(input ALU_OPERATION op);
      return (op == ALU_ADD) || (op == ALU_SUB);
   endfunction

endpackage

// File: rtl/alu_multiword_sequencer_if.sv
// rtl/alu_multiword_sequencer_if.sv - command, operand and result handshakes of the sequencer
interface alu_multiword_sequencer_if
   import alu_multiword_sequencer_pkg::*;
#(
   parameter int LEN_W = SEQ_LEN_W
);
   logic               abort;
   logic               start;
   logic               start_ready;
   ALU_OPERATION       start_op;
   logic [LEN_W-1:0]   start_len;
   logic               start_cin;
   logic               in_valid;
   logic               in_ready;
   MICRO1_MACHINE_WORD in_left;
   MICRO1_MACHINE_WORD in_right;
   logic               out_valid;
   logic               out_ready;
   MICRO1_MACHINE_WORD out_result;
   logic               out_last;
   logic               done;
   logic               done_cout;
   logic               busy;

   modport master (
      output abort, start, start_op, start_len, start_cin,
      output in_valid, in_left, in_right, out_ready,
      input  start_ready, in_ready, out_valid, out_result, out_last,
      input  done, done_cout, busy
   );

   modport slave (
      input  abort, start, start_op, start_len, start_cin,
      input  in_valid, in_left, in_right, out_ready,
      output start_ready, in_ready, out_valid, out_result, out_last,
      output done, done_cout, busy
   );
endinterface

// File: rtl/alu_multiword_sequencer_alu.sv
// rtl/alu_multiword_sequencer_alu.sv - single-word alu with the chained carry and result register
module alu_multiword_sequencer_alu
   import alu_multiword_sequencer_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               load,
   input  logic               load_cin,
   input  ALU_OPERATION       op,
   input  logic               word_fire,
   input  logic               last_word,
   input  MICRO1_MACHINE_WORD left,
   input  MICRO1_MACHINE_WORD right,
   input  logic               out_ready,
   output logic               out_valid,
   output MICRO1_MACHINE_WORD out_result,
   output logic               out_last,
   output logic               carry
);
   logic [WORD_W:0]    sum;
   logic               carry_q, carry_d;
   logic               valid_q, valid_d;
   logic               last_q, last_d;
   MICRO1_MACHINE_WORD result_q, result_d;

   // For SUB the carry bit acts as a borrow: the top bit of the widened difference.
   always_comb begin
      sum = '0;
      case (op)
         ALU_ADD: sum = {1'b0, left} + {1'b0, right} + {{WORD_W{1'b0}}, carry_q};
         ALU_SUB: sum = {1'b0, left} - {1'b0, right} - {{WORD_W{1'b0}}, carry_q};
         ALU_AND: sum = {1'b0, left & right};
         ALU_OR:  sum = {1'b0, left | right};
         ALU_XOR: sum = {1'b0, left ^ right};
         default: sum = '0;
      endcase
   end

   always_comb begin
      carry_d  = carry_q;
      valid_d  = valid_q;
      last_d   = last_q;
      result_d = result_q;
      if (valid_q && out_ready) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end
      if (load) begin
         carry_d = load_cin;
      end
      if (word_fire) begin
         valid_d  = 1'b1;
         last_d   = last_word;
         result_d = sum[WORD_W-1:0];
         carry_d  = alu_op_chains_carry(op) ? sum[WORD_W] : 1'b0;
      end
      if (clear) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         carry_q  <= 1'b0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         result_q <= '0;
      end else begin
         carry_q  <= carry_d;
         valid_q  <= valid_d;
         last_q   <= last_d;
         result_q <= result_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_result = result_q;
   assign out_last   = last_q;
   assign carry      = carry_q;
endmodule

// File: rtl/alu_multiword_sequencer.sv
// rtl/alu_multiword_sequencer.sv - runs the shared alu over 1..MAX_WORDS operand words, LS word first
module alu_multiword_sequencer
   import alu_multiword_sequencer_pkg::*;
#(
   parameter int MAX_WORDS = SEQ_MAX_WORDS,
   parameter int LEN_W     = $clog2(MAX_WORDS + 1)
)
(
   input  logic clk,
   input  logic reset,
   alu_multiword_sequencer_if.slave bus
);
   ALU_SEQ_STATE       state_q, state_d;
   ALU_OPERATION       op_q, op_d;
   logic [LEN_W-1:0]   remaining_q, remaining_d;
   logic               done_q, done_d;
   logic               done_cout_q, done_cout_d;
   logic [LEN_W-1:0]   len_clamped;
   logic               start_ready;
   logic               in_ready;
   logic               load;
   logic               load_cin;
   logic               word_fire;
   logic               last_word;
   logic               dp_out_valid;
   MICRO1_MACHINE_WORD dp_out_result;
   logic               dp_out_last;
   logic               carry;

   always_comb begin
      len_clamped = (bus.start_len > LEN_W'(MAX_WORDS)) ? LEN_W'(MAX_WORDS) : bus.start_len;
      // A zero-length operation has no words, so its reported carry is forced to 0.
      load_cin = alu_op_chains_carry(bus.start_op) && bus.start_cin && (len_clamped != '0);
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      remaining_d = remaining_q;
      done_d      = 1'b0;
      done_cout_d = done_cout_q;
      start_ready = 1'b0;
      in_ready    = 1'b0;
      load        = 1'b0;
      word_fire   = 1'b0;
      last_word   = 1'b0;
      case (state_q)
         ALU_SEQ_IDLE: begin
            start_ready = 1'b1;
            if (bus.start) begin
               load        = 1'b1;
               op_d        = bus.start_op;
               remaining_d = len_clamped;
               state_d     = (len_clamped == '0) ? ALU_SEQ_FLUSH : ALU_SEQ_RUN;
            end
         end
         ALU_SEQ_RUN: begin
            in_ready = !dp_out_valid || bus.out_ready;
            if (bus.in_valid && in_ready) begin
               word_fire   = 1'b1;
               last_word   = (remaining_q == LEN_W'(1));
               remaining_d = remaining_q - LEN_W'(1);
               if (last_word) begin
                  state_d = ALU_SEQ_FLUSH;
               end
            end
         end
         ALU_SEQ_FLUSH: begin
            if (!dp_out_valid || bus.out_ready) begin
               state_d     = ALU_SEQ_IDLE;
               done_d      = 1'b1;
               done_cout_d = carry;
            end
         end
         default: state_d = ALU_SEQ_IDLE;
      endcase
      if (bus.abort) begin
         state_d     = ALU_SEQ_IDLE;
         op_d        = op_q;
         remaining_d = remaining_q;
         done_d      = 1'b0;
         done_cout_d = done_cout_q;
         load        = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ALU_SEQ_IDLE;
         op_q        <= ALU_ADD;
         remaining_q <= '0;
         done_q      <= 1'b0;
         done_cout_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         remaining_q <= remaining_d;
         done_q      <= done_d;
         done_cout_q <= done_cout_d;
      end
   end

   alu_multiword_sequencer_alu u_alu (
      .clk        (clk),
      .reset      (reset),
      .clear      (bus.abort),
      .load       (load),
      .load_cin   (load_cin),
      .op         (op_q),
      .word_fire  (word_fire),
      .last_word  (last_word),
      .left       (bus.in_left),
      .right      (bus.in_right),
      .out_ready  (bus.out_ready),
      .out_valid  (dp_out_valid),
      .out_result (dp_out_result),
      .out_last   (dp_out_last),
      .carry      (carry)
   );

   assign bus.start_ready = start_ready;
   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = dp_out_valid;
   assign bus.out_result  = dp_out_result;
   assign bus.out_last    = dp_out_last;
   assign bus.done        = done_q;
   assign bus.done_cout   = done_cout_q;
   assign bus.busy        = (state_q != ALU_SEQ_IDLE);
endmodule

// File: tb/tb_alu_multiword_sequencer.sv
// tb/tb_alu_multiword_sequencer.sv - vector table and scoreboard bench for alu_multiword_sequencer
module tb_alu_multiword_sequencer;
   import alu_multiword_sequencer_pkg::*;

   typedef struct packed {
      ALU_OPERATION   op;
      logic [3:0]     len;
      logic           cin;
      logic [3:0]     n;
      logic [7:0][31:0] l;
      logic [7:0][31:0] r;
      logic [7:0][31:0] e;
      logic           cout;
   } vec_t;

   localparam int NV = 8;

   logic        clk;
   logic        reset;
   int          checks;
   int          errors;
   bit          bp;
   vec_t        vecs [NV];
   logic [32:0] sb [$];

   alu_multiword_sequencer_if #(.LEN_W(SEQ_LEN_W)) ifc ();

   alu_multiword_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic mon();
      logic [32:0] e;
      if (ifc.out_valid && ifc.out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%h required=none", ifc.out_result);
         end else begin
            e = sb.pop_front();
            chk("out_result", ifc.out_result, e[31:0]);
            chk("out_last", 32'(ifc.out_last), 32'(e[32]));
         end
      end
   endtask

   // Every cycle passes through at_neg (sample + scoreboard) then at_pos (drive).
   task automatic at_neg();
      @(negedge clk);
      mon();
   endtask

   task automatic at_pos();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input ALU_OPERATION op, input logic [3:0] len, input logic cin);
      ifc.start     = 1'b1;
      ifc.start_op  = op;
      ifc.start_len = len;
      ifc.start_cin = cin;
      at_neg();
      chk("start_ready", 32'(ifc.start_ready), 32'd1);
      at_pos();
      ifc.start = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] l, input logic [31:0] r,
                            input logic [31:0] e, input logic last);
      bit ok;
      ok = 1'b0;
      ifc.in_valid = 1'b1;
      ifc.in_left  = l;
      ifc.in_right = r;
      for (int i = 0; i < 64 && !ok; i++) begin
         if (bp) ifc.out_ready = 1'($urandom_range(0, 1));
         at_neg();
         if (ifc.in_ready) begin
            sb.push_back({last, e});
            ok = 1'b1;
         end
         at_pos();
      end
      ifc.in_valid = 1'b0;
      chk("in_accept", 32'(ok), 32'd1);
   endtask

   task automatic wait_done(input logic cout);
      bit found;
      found = 1'b0;
      ifc.in_valid  = 1'b0;
      ifc.out_ready = 1'b1;
      for (int i = 0; i < 64 && !found; i++) begin
         at_neg();
         if (ifc.done) begin
            found = 1'b1;
            chk("done_cout", 32'(ifc.done_cout), 32'(cout));
            chk("sb_empty_at_done", 32'(sb.size()), 32'd0);
            chk("busy_at_done", 32'(ifc.busy), 32'd0);
         end
         at_pos();
      end
      chk("done_seen", 32'(found), 32'd1);
   endtask

   task automatic set_vec(input int i, input ALU_OPERATION op, input logic [3:0] len,
                          input logic cin, input logic [3:0] n, input logic cout);
      vecs[i]      = '0;
      vecs[i].op   = op;
      vecs[i].len  = len;
      vecs[i].cin  = cin;
      vecs[i].n    = n;
      vecs[i].cout = cout;
   endtask

   task automatic set_word(input int i, input int w, input logic [31:0] l,
                           input logic [31:0] r, input logic [31:0] e);
      vecs[i].l[w] = l;
      vecs[i].r[w] = r;
      vecs[i].e[w] = e;
   endtask

   task automatic run_vec(input int i);
      int n;
      n = int'(vecs[i].n);
      do_start(vecs[i].op, vecs[i].len, vecs[i].cin);
      for (int w = 0; w < n; w++) begin
         send_word(vecs[i].l[w], vecs[i].r[w], vecs[i].e[w], w == n - 1);
      end
      wait_done(vecs[i].cout);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      bp     = 1'b0;

      set_vec(0, ALU_ADD, 4'd2, 1'b0, 4'd2, 1'b0);
      set_word(0, 0, 32'hFFFF_FFFF, 32'h1, 32'h0);
      set_word(0, 1, 32'h0, 32'h0, 32'h1);
      set_vec(1, ALU_ADD, 4'd1, 1'b1, 4'd1, 1'b1);
      set_word(1, 0, 32'hFFFF_FFFF, 32'h0, 32'h0);
      set_vec(2, ALU_SUB, 4'd2, 1'b0, 4'd2, 1'b0);
      set_word(2, 0, 32'h0, 32'h1, 32'hFFFF_FFFF);
      set_word(2, 1, 32'h5, 32'h2, 32'h2);
      set_vec(3, ALU_XOR, 4'd3, 1'b1, 4'd3, 1'b0);
      for (int w = 0; w < 3; w++) set_word(3, w, 32'hFFFF_FFFF, 32'h5, 32'hFFFF_FFFA);
      set_vec(4, ALU_AND, 4'd2, 1'b0, 4'd2, 1'b0);
      set_word(4, 0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
      set_word(4, 1, 32'h1234_5678, 32'h0000_FFFF, 32'h0000_5678);
      set_vec(5, ALU_OR, 4'd1, 1'b1, 4'd1, 1'b0);
      set_word(5, 0, 32'hA000_0000, 32'h0000_000B, 32'hA000_000B);
      set_vec(6, ALU_ADD, 4'd15, 1'b1, 4'd8, 1'b1);
      for (int w = 0; w < 8; w++) set_word(6, w, 32'hFFFF_FFFF, 32'h0, 32'h0);
      set_vec(7, ALU_SUB, 4'd3, 1'b1, 4'd3, 1'b1);
      set_word(7, 0, 32'hA, 32'h3, 32'h6);
      set_word(7, 1, 32'h0, 32'h0, 32'h0);
      set_word(7, 2, 32'h0, 32'h1, 32'hFFFF_FFFF);

      reset         = 1'b1;
      ifc.abort     = 1'b0;
      ifc.start     = 1'b0;
      ifc.start_op  = ALU_ADD;
      ifc.start_len = '0;
      ifc.start_cin = 1'b0;
      ifc.in_valid  = 1'b0;
      ifc.in_left   = '0;
      ifc.in_right  = '0;
      ifc.out_ready = 1'b1;
      at_neg();
      chk("rst_start_ready", 32'(ifc.start_ready), 32'd1);
      chk("rst_in_ready", 32'(ifc.in_ready), 32'd0);
      chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("rst_out_last", 32'(ifc.out_last), 32'd0);
      chk("rst_out_result", ifc.out_result, 32'd0);
      chk("rst_done", 32'(ifc.done), 32'd0);
      chk("rst_done_cout", 32'(ifc.done_cout), 32'd0);
      chk("rst_busy", 32'(ifc.busy), 32'd0);
      at_pos();
      reset = 1'b0;
      at_neg();
      at_pos();

      for (int p = 0; p < 2; p++) begin
         bp = (p == 1);
         for (int i = 0; i < NV; i++) run_vec(i);
      end
      bp = 1'b0;
      ifc.out_ready = 1'b1;

      // Abort after one of four words: no done, done_cout keeps the previous value (1).
      do_start(ALU_ADD, 4'd4, 1'b0);
      send_word(32'h1, 32'h1, 32'h2, 1'b0);
      ifc.abort = 1'b1;
      at_neg();
      at_pos();
      ifc.abort = 1'b0;
      at_neg();
      chk("abort_busy", 32'(ifc.busy), 32'd0);
      chk("abort_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("abort_done", 32'(ifc.done), 32'd0);
      chk("abort_done_cout", 32'(ifc.done_cout), 32'd1);
      chk("abort_start_ready", 32'(ifc.start_ready), 32'd1);
      at_pos();
      at_neg();
      chk("abort_no_late_done", 32'(ifc.done), 32'd0);
      at_pos();

      ifc.start     = 1'b1;
      ifc.abort     = 1'b1;
      ifc.start_len = 4'd2;
      at_neg();
      at_pos();
      ifc.start = 1'b0;
      ifc.abort = 1'b0;
      at_neg();
      chk("abort_beats_start", 32'(ifc.busy), 32'd0);
      at_pos();

      do_start(ALU_ADD, 4'd0, 1'b1);
      at_neg();
      chk("len0_busy", 32'(ifc.busy), 32'd1);
      chk("len0_done_early", 32'(ifc.done), 32'd0);
      at_pos();
      at_neg();
      chk("len0_done", 32'(ifc.done), 32'd1);
      chk("len0_done_cout", 32'(ifc.done_cout), 32'd0);
      at_pos();

      // Output backpressure mid-stream, then held at the final word.
      do_start(ALU_ADD, 4'd4, 1'b0);
      send_word(32'h1, 32'h2, 32'h3, 1'b0);
      ifc.out_ready = 1'b0;
      ifc.in_valid  = 1'b1;
      ifc.in_left   = 32'h3;
      ifc.in_right  = 32'h4;
      for (int c = 0; c < 4; c++) begin
         at_neg();
         chk("stall_in_ready", 32'(ifc.in_ready), 32'd0);
         chk("stall_out_valid", 32'(ifc.out_valid), 32'd1);
         chk("stall_out_result", ifc.out_result, 32'h3);
         chk("stall_start_ready", 32'(ifc.start_ready), 32'd0);
         at_pos();
      end
      ifc.out_ready = 1'b1;
      send_word(32'h3, 32'h4, 32'h7, 1'b0);
      send_word(32'h5, 32'h6, 32'hB, 1'b0);
      send_word(32'h7, 32'h8, 32'hF, 1'b1);
      ifc.out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         at_neg();
         chk("tail_done", 32'(ifc.done), 32'd0);
         chk("tail_busy", 32'(ifc.busy), 32'd1);
         chk("tail_out_last", 32'(ifc.out_last), 32'd1);
         at_pos();
      end
      wait_done(1'b0);

      do_start(ALU_ADD, 4'd2, 1'b0);
      ifc.out_ready = 1'b0;
      send_word(32'h1, 32'h1, 32'h2, 1'b0);
      at_neg();
      chk("pre_reset_out_valid", 32'(ifc.out_valid), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("async_rst_busy", 32'(ifc.busy), 32'd0);
      chk("async_rst_out_result", ifc.out_result, 32'd0);
      chk("async_rst_start_ready", 32'(ifc.start_ready), 32'd1);
      sb.delete();
      at_pos();
      reset = 1'b0;
      ifc.out_ready = 1'b1;
      at_neg();
      at_pos();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
